// File: rtl/i2s_receiver.sv
// ----------------------------------------------------------------------------
// i2s_receiver
//   Oversampling I2S capture block. Synchronizes sck/ws/sd into the clk
//   domain, detects sck rising edges, shifts in MSB-first data, and uses ws
//   transitions (Philips convention: ws changes one bit before the MSB) to
//   frame left/right words. A complete left/right pair is presented on
//   audio0_out/audio1_out together with a one-cycle valid_out pulse; a word
//   of the wrong length produces a one-cycle frame_err_out pulse and a
//   resynchronization on the next end-of-right-word boundary.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   enable_in     capture enable (level)
//   sck_in        I2S bit clock (asynchronous to clk)
//   ws_in         word select, 0 = left, 1 = right
//   sd_in         serial data, MSB first
//   audio0_out    last complete left sample
//   audio1_out    last complete right sample
//   valid_out     one-cycle pulse when audio0_out/audio1_out update
//   frame_err_out one-cycle pulse on a malformed word
// ----------------------------------------------------------------------------
module i2s_receiver #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_in,
  input  logic                    sck_in,
  input  logic                    ws_in,
  input  logic                    sd_in,
  output logic [SAMPLE_WIDTH-1:0] audio0_out,
  output logic [SAMPLE_WIDTH-1:0] audio1_out,
  output logic                    valid_out,
  output logic                    frame_err_out
);

  typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} state_t;

  // bit_cnt saturates at SAMPLE_WIDTH+1, so it needs room for that value.
  localparam int CW = $clog2(SAMPLE_WIDTH + 2);

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sck_sync, ws_sync, sd_sync;
  logic                    sck_q, sck_q_prev;
  logic                    ws_prev;
  logic [CW-1:0]           bit_cnt;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_next, left_hold;
  logic                    ws_s, sd_s, rise, boundary, word_ok;
  logic                    valid_d, err_d, load_left, load_out;

  assign ws_s       = ws_sync[SYNC_STAGES-1];
  assign sd_s       = sd_sync[SYNC_STAGES-1];
  // Edge detect runs on the extra register behind the sck synchronizer;
  // ws/sd come straight off their synchronizers and are therefore sampled
  // a cycle later relative to sck, well inside their stable window.
  assign rise       = sck_q & ~sck_q_prev;
  assign boundary   = rise & (ws_s != ws_prev);
  // At a boundary bit_cnt has not yet counted the LSB being sampled.
  assign word_ok    = (bit_cnt == CW'(SAMPLE_WIDTH - 1));
  assign shift_next = {shift_q[SAMPLE_WIDTH-2:0], sd_s};

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync   <= '0;
      ws_sync    <= '0;
      sd_sync    <= '0;
      sck_q      <= 1'b0;
      sck_q_prev <= 1'b0;
    end else begin
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      ws_sync    <= {ws_sync[SYNC_STAGES-2:0], ws_in};
      sd_sync    <= {sd_sync[SYNC_STAGES-2:0], sd_in};
      sck_q      <= sck_sync[SYNC_STAGES-1];
      sck_q_prev <= sck_q;
    end
  end

  // Next-state and pulse decode. Disable takes priority over everything,
  // so a malformed word coinciding with enable_in=0 raises no error.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    load_left = 1'b0;
    load_out  = 1'b0;
    if (!enable_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = SYNC;
        SYNC: if (boundary && !ws_s) state_d = LEFT;
        LEFT: begin
          if (boundary) begin
            if (word_ok) begin
              load_left = 1'b1;
              state_d   = RIGHT;
            end else begin
              err_d   = 1'b1;
              state_d = SYNC;
            end
          end
        end
        RIGHT: begin
          if (boundary) begin
            if (word_ok) begin
              load_out = 1'b1;
              valid_d  = 1'b1;
              state_d  = LEFT;
            end else begin
              err_d   = 1'b1;
              state_d = SYNC;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ws_prev       <= 1'b0;
      bit_cnt       <= '0;
      shift_q       <= '0;
      left_hold     <= '0;
      audio0_out    <= '0;
      audio1_out    <= '0;
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      state_q       <= state_d;
      valid_out     <= valid_d;
      frame_err_out <= err_d;
      // ws_prev tracks the line even while idle so that re-enabling never
      // sees a stale value and mistakes it for a word boundary.
      if (rise) ws_prev <= ws_s;
      if (state_q == IDLE) begin
        bit_cnt <= '0;
      end else if (rise) begin
        shift_q <= shift_next;
        if (boundary)
          bit_cnt <= '0;
        else if (bit_cnt != CW'(SAMPLE_WIDTH + 1))
          bit_cnt <= bit_cnt + CW'(1);
      end
      if (load_left) left_hold <= shift_next;
      if (load_out) begin
        audio0_out <= left_hold;
        audio1_out <= shift_next;
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// ----------------------------------------------------------------------------
// tb_i2s_receiver
//   Directed bench for i2s_receiver: drives an I2S stream with an sck half
//   period of five clk cycles and checks captured samples, pulse counts,
//   valid_out latency, error handling, enable and reset behaviour.
// ----------------------------------------------------------------------------
module tb_i2s_receiver;

  localparam int SW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_in = 1'b0;
  logic          sck_in = 1'b0;
  logic          ws_in = 1'b0;
  logic          sd_in = 1'b0;
  logic [SW-1:0] audio0_out, audio1_out;
  logic          valid_out, frame_err_out;

  int asserts = 0;
  int fails   = 0;

  // Monitor state: pulse counters, cycle stamps and last captured pair.
  int            cyc = 0;
  int            valid_cnt = 0;
  int            err_cnt = 0;
  int            valid_cyc = 0;
  int            rise_cyc = 0;
  logic [SW-1:0] cap0 = '0, cap1 = '0;

  i2s_receiver #(.SAMPLE_WIDTH(SW), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_in    (enable_in),
    .sck_in       (sck_in),
    .ws_in        (ws_in),
    .sd_in        (sd_in),
    .audio0_out   (audio0_out),
    .audio1_out   (audio1_out),
    .valid_out    (valid_out),
    .frame_err_out(frame_err_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid_out) begin
      valid_cnt++;
      valid_cyc = cyc;
      cap0      = audio0_out;
      cap1      = audio1_out;
    end
    if (frame_err_out) err_cnt++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // One sck period: ws/sd change while sck is low, then sck rises.
  task automatic sck_bit(input logic w, input logic d);
    @(posedge clk); #1;
    sck_in = 1'b0;
    ws_in  = w;
    sd_in  = d;
    repeat (5) @(posedge clk);
    #1;
    sck_in   = 1'b1;
    rise_cyc = cyc;
    repeat (5) @(posedge clk);
  endtask

  // n-bit word on channel w; the LSB goes out with ws already toggled.
  task automatic send_word(input logic w, input logic [SW-1:0] data, input int n);
    for (int i = n - 1; i >= 1; i--) sck_bit(w, data[i]);
    sck_bit(~w, data[0]);
  endtask

  task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
    send_word(1'b0, l, SW);
    send_word(1'b1, r, SW);
  endtask

  // Tail of a right word ending in a ws 1->0 boundary, so the receiver syncs.
  task automatic send_preamble();
    repeat (3) sck_bit(1'b1, 1'b1);
    sck_bit(1'b0, 1'b0);
  endtask

  task automatic check_pair(input string name, input int v0, input logic [SW-1:0] e0,
                            input logic [SW-1:0] e1, input logic check_lat);
    asserts++;
    if (valid_cnt - v0 !== 1) begin
      $display("FAIL %s valid count: got %0d required 1", name, valid_cnt - v0);
      fails++;
    end
    asserts++;
    if (cap0 !== e0) begin
      $display("FAIL %s audio0: got %h required %h", name, cap0, e0);
      fails++;
    end
    asserts++;
    if (cap1 !== e1) begin
      $display("FAIL %s audio1: got %h required %h", name, cap1, e1);
      fails++;
    end
    if (check_lat) begin
      asserts++;
      if (valid_cyc - rise_cyc !== 4) begin
        $display("FAIL %s latency: got %0d clk required 4", name, valid_cyc - rise_cyc);
        fails++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      sck_in    = 1'($urandom);
      ws_in     = 1'($urandom);
      sd_in     = 1'($urandom);
      enable_in = 1'($urandom);
    end
    @(negedge clk);
    asserts++;
    if (audio0_out !== '0 || audio1_out !== '0) begin
      $display("FAIL reset audio: got %h/%h required 0/0", audio0_out, audio1_out);
      fails++;
    end
    asserts++;
    if (valid_out !== 1'b0 || frame_err_out !== 1'b0) begin
      $display("FAIL reset pulses: got %b/%b required 0/0", valid_out, frame_err_out);
      fails++;
    end
    enable_in = 1'b0;
    sck_in    = 1'b0;
    ws_in     = 1'b0;
    sd_in     = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // A full frame while disabled must produce nothing.
    send_preamble();
    send_frame(24'h123456, 24'hABCDEF);
    asserts++;
    if (valid_cnt !== 0 || err_cnt !== 0) begin
      $display("FAIL disabled pulses: got valid=%0d err=%0d required 0/0", valid_cnt, err_cnt);
      fails++;
    end
    asserts++;
    if (audio0_out !== '0 || audio1_out !== '0) begin
      $display("FAIL disabled audio: got %h/%h required 0/0", audio0_out, audio1_out);
      fails++;
    end
  endtask

  task automatic test_frames();
    int v0;
    enable_in = 1'b1;
    repeat (4) @(posedge clk);
    send_preamble();
    v0 = valid_cnt;
    send_frame(24'h123456, 24'hABCDEF);
    check_pair("frame1", v0, 24'h123456, 24'hABCDEF, 1'b1);
    v0 = valid_cnt;
    send_frame(24'h800001, 24'h7FFFFE);
    check_pair("frame2", v0, 24'h800001, 24'h7FFFFE, 1'b1);
    asserts++;
    if (err_cnt !== 0) begin
      $display("FAIL frames errors: got %0d required 0", err_cnt);
      fails++;
    end
  endtask

  task automatic test_mid_enable();
    int v0;
    enable_in = 1'b0;
    repeat (4) @(posedge clk);
    v0 = valid_cnt;
    repeat (10) sck_bit(1'b1, 1'b1);
    enable_in = 1'b1;
    repeat (13) sck_bit(1'b1, 1'b0);
    sck_bit(1'b0, 1'b1);
    asserts++;
    if (valid_cnt !== v0) begin
      $display("FAIL mid_enable partial: got %0d valid pulses required 0", valid_cnt - v0);
      fails++;
    end
    send_frame(24'h5A5A5A, 24'h0F0F0F);
    check_pair("mid_enable", v0, 24'h5A5A5A, 24'h0F0F0F, 1'b1);
  endtask

  task automatic test_short_word();
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_word(1'b0, 24'h7FFFFF, 23);
    send_word(1'b1, 24'h333333, SW);
    asserts++;
    if (err_cnt - e0 !== 1) begin
      $display("FAIL short_word err: got %0d pulses required 1", err_cnt - e0);
      fails++;
    end
    asserts++;
    if (valid_cnt !== v0) begin
      $display("FAIL short_word valid: got %0d pulses required 0", valid_cnt - v0);
      fails++;
    end
    asserts++;
    if (audio0_out !== 24'h5A5A5A || audio1_out !== 24'h0F0F0F) begin
      $display("FAIL short_word hold: got %h/%h required 5a5a5a/0f0f0f", audio0_out, audio1_out);
      fails++;
    end
    send_frame(24'h000001, 24'hFFFFFF);
    check_pair("after_short", v0, 24'h000001, 24'hFFFFFF, 1'b1);
  endtask

  task automatic test_disable_mid();
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int i = 23; i >= 14; i--) sck_bit(1'b0, 1'b1);
    enable_in = 1'b0;
    repeat (3) @(posedge clk);
    enable_in = 1'b1;
    for (int i = 13; i >= 1; i--) sck_bit(1'b0, 1'b0);
    sck_bit(1'b1, 1'b1);
    send_word(1'b1, 24'h444444, SW);
    asserts++;
    if (valid_cnt !== v0 || err_cnt !== e0) begin
      $display("FAIL disable_mid dropped: got valid=%0d err=%0d required 0/0",
               valid_cnt - v0, err_cnt - e0);
      fails++;
    end
    send_frame(24'h13579B, 24'h2468AC);
    check_pair("disable_mid", v0, 24'h13579B, 24'h2468AC, 1'b0);
    asserts++;
    if (err_cnt !== e0) begin
      $display("FAIL disable_mid err: got %0d pulses required 0", err_cnt - e0);
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    send_word(1'b0, 24'h999999, SW);
    repeat (10) sck_bit(1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    asserts++;
    if (audio0_out !== '0 || audio1_out !== '0 || valid_out !== 1'b0) begin
      $display("FAIL reset_mid outputs: got %h/%h/%b required 0/0/0",
               audio0_out, audio1_out, valid_out);
      fails++;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    v0 = valid_cnt;
    repeat (13) sck_bit(1'b1, 1'b0);
    sck_bit(1'b0, 1'b0);
    send_frame(24'hCAFE01, 24'h00BEEF);
    check_pair("reset_mid", v0, 24'hCAFE01, 24'h00BEEF, 1'b1);
  endtask

  initial begin
    test_reset();
    test_frames();
    test_mid_enable();
    test_short_word();
    test_disable_mid();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/i2s_receiver.md
# i2s_receiver

I2S capture block that deserializes a stereo I2S stream (sck, ws, sd) back into parallel 24-bit left/right samples. It is the receiving end of the audioport I2S output and sits on the system clock `clk`. It oversamples the serial lines, recovers word boundaries from ws, and delivers one left/right pair per 48-bit frame. It serves as the loopback checker in audioport system tests and as the capture path for a future audio input channel.

## Interface
- Clocking: one clock; reset is asynchronous and active-low.
- SAMPLE_WIDTH, default 24: bits per channel word. At 48 kHz, sck = mclk/MCLK_DIV_48000, giving 48 sck cycles per frame.
- SYNC_STAGES, default 2: synchronizer flops on each serial input (minimum 2).
- clk  in  1  system clock (10 ns).
- rst_n  in  1  asynchronous active-low reset.
- enable_in  in  1  capture enable; level-sensitive.
- sck_in  in  1  I2S bit clock, asynchronous to clk.
- ws_in  in  1  word select: 0 = left (audio0), 1 = right (audio1).
- sd_in  in  1  serial data, MSB first.
- audio0_out  out  SAMPLE_WIDTH  last complete left sample.
- audio1_out  out  SAMPLE_WIDTH  last complete right sample.
- valid_out  out  1  one-cycle pulse when audio0_out/audio1_out update.
- frame_err_out  out  1  one-cycle pulse on a malformed word.

## Operation
- Input conditioning
  - sck_in, ws_in and sd_in each pass through SYNC_STAGES flops, then one extra register on synced sck.
  - `rise` = synced sck is 1 and its previous value is 0.
  - All protocol logic advances only in `rise` cycles.
- Bit capture
  - On each `rise`, shift synced sd into the LSB of a SAMPLE_WIDTH shift register.
  - Record synced ws as ws_prev.
  - Increment bit_cnt, saturating at SAMPLE_WIDTH+1.
- Word boundary
  - A boundary is a `rise` where ws ≠ ws_prev (Philips I2S convention).
  - The bit sampled at the boundary rise is the LSB of the word belonging to ws_prev.
  - The next rise samples the MSB of the new word. bit_cnt resets to 0 after the boundary.
- States
  - IDLE: enable_in=0. bit_cnt=0; shift register and outputs hold.
  - SYNC: waiting for a ws 1→0 boundary, i.e. the end of a right word. Any partial data is discarded. On that boundary go to LEFT.
  - LEFT: at the ws 0→1 boundary:
    - if bit_cnt (including the LSB just sampled) == SAMPLE_WIDTH, copy the shift register to left_hold and go to RIGHT;
    - otherwise pulse frame_err_out and go to SYNC.
  - RIGHT: at the ws 1→0 boundary:
    - if bit_cnt == SAMPLE_WIDTH, load audio0_out←left_hold and audio1_out←shift register, pulse valid_out, and go to LEFT;
    - otherwise pulse frame_err_out and go to SYNC.
  - From any state, enable_in=0 goes to IDLE next cycle. From IDLE, enable_in=1 goes to SYNC.
- Boundary conditions
  - Word too short or too long: frame_err_out pulse, no valid_out, resynchronize. Neither audio output changes.
  - enable_in falls mid-frame: the partial frame is dropped with no valid_out and no frame_err_out.
  - Enable in the same cycle as a `rise`: that rise is ignored, since the state is still IDLE.
  - Simultaneous error and disable: the disable wins, so no frame_err_out.
  - Reset mid-operation: immediate return to the reset state, then IDLE.
- Reset values: audio0_out=0, audio1_out=0, valid_out=0, frame_err_out=0, state IDLE, shift register, left_hold and bit_cnt all 0, ws_prev=0.

## Timing
- Output timing
  - valid_out and frame_err_out are registered. Each asserts in the cycle after the boundary `rise` cycle, for exactly 1 clk.
  - audio*_out change in the same cycle as valid_out and hold until the next valid_out.
- Latency from the external sck rising edge at the right-word LSB to valid_out high: SYNC_STAGES+2 clk cycles (4 clk by default).
- Requirements on sck
  - sck high and low phases must each be ≥ SYNC_STAGES+1 clk periods.
  - ws and sd must be stable for ≥ 2 clk around each sck rising edge.
  - The audioport's ~217 ns half-period against the 10 ns clk meets this.
- Throughput: one valid_out per frame, every 48 sck periods at 48 kHz.

## Test plan
- Reset with random inputs toggling → all outputs 0; no valid_out or frame_err_out until enable_in=1 and a full frame has arrived.
- Enable before a frame boundary, then send frames L=0x123456/R=0xABCDEF and L=0x800001/R=0x7FFFFE → exactly one valid_out per frame with matching values, 4 clk after the right-LSB sck edge.
- Enable in the middle of a right word → partial frame discarded; first valid_out carries the first complete L/R pair.
- Left word of 23 bits, then a good frame L=0x000001/R=0xFFFFFF → one frame_err_out pulse, no valid_out for the bad frame, outputs unchanged, then a correct valid_out.
- Deassert enable_in mid-left-word, then reassert → no valid_out and no frame_err_out for the dropped frame; capture resumes after the next ws 1→0 boundary.
- Assert rst_n=0 mid-right-word → outputs 0 immediately; after release and enable, the next full frame is captured correctly.
